// File: rtl/card_pkg.sv
// Shared card types, card geometry and the blackjack card value helper.
package card_pkg;

    localparam int CARD_W = 55;
    localparam int CARD_H = 79;

    typedef logic [3:0] rank_t;   // 1=A .. 13=K
    typedef logic [1:0] suit_t;

    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;

    typedef struct packed {
        logic  dealer;
        card_t card;
    } deal_req_t;

    // Blackjack value of one card, aces counted high.
    function automatic logic [4:0] card_value(input rank_t r);
        if (r == 4'd1)
            return 5'd11;
        else if (r >= 4'd10)
            return 5'd10;
        else
            return {1'b0, r};
    endfunction

endpackage

// File: rtl/card_score_unit.sv
// Hand scoring: sums the selected cards on start, then demotes one soft ace
// (11 -> 1) per cycle while the total is over 21. done pulses when settled.
module card_score_unit
    import card_pkg::*;
#(
    parameter int MAX_CARDS = 6
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  rank_t [MAX_CARDS-1:0]      ranks,
    input  logic  [MAX_CARDS-1:0]      use_mask,
    output logic                       done,
    output logic  [4:0]                score
);
    localparam int SW = $clog2(11 * MAX_CARDS + 1);
    localparam int AW = $clog2(MAX_CARDS + 1);

    logic [SW-1:0] sum_c, tot;
    logic [AW-1:0] aces_c, aces;
    logic          run, reduce;

    // Raw total and ace count over the selected slots.
    always_comb begin
        sum_c  = '0;
        aces_c = '0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (use_mask[i]) begin
                sum_c = sum_c + SW'(card_value(ranks[i]));
                if (ranks[i] == 4'd1)
                    aces_c = aces_c + 1'b1;
            end
        end
    end

    assign reduce = (tot > SW'(21)) && (aces != '0);
    assign done   = run && !reduce;
    // A busted hand can run past 31; saturate so bust stays visible in 5 bits.
    assign score  = (tot > SW'(31)) ? 5'd31 : tot[4:0];

    // Load on start, then one ace reduction step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            run  <= 1'b0;
            tot  <= '0;
            aces <= '0;
        end else if (start) begin
            run  <= 1'b1;
            tot  <= sum_c;
            aces <= aces_c;
        end else if (run) begin
            if (reduce) begin
                tot  <= tot - SW'(10);
                aces <= aces - 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/card_slot_ctrl.sv
// Card table controller: player/dealer hands, vblank-synchronised deal and
// clear, score tracking and a registered per-pixel slot lookup for the overlay.
// Optional hole card handling: define CARD_SLOT_HOLE_CARD_EN.
module card_slot_ctrl
    import card_pkg::*;
#(
    parameter int MAX_CARDS  = 6,
    parameter int SLOT_PITCH = 60,
    parameter int PLAYER_Y   = 400,
    parameter int DEALER_Y   = 30,
    parameter int FIRST_X    = 20
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        deal_valid,
    output logic        deal_ready,
    input  logic        deal_dealer,
    input  logic [5:0]  deal_card,
    input  logic        clear_req,
    input  logic        reveal,
    input  logic        vblnk_in,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    output logic        slot_hit,
    output logic [5:0]  slot_card,
    output logic        slot_face_down,
    output logic [5:0]  slot_xoff,
    output logic [6:0]  slot_yoff,
    output logic [4:0]  player_score,
    output logic [4:0]  dealer_score,
    output logic        player_bust,
    output logic        dealer_bust,
    output logic        busy
);
    localparam int CW = $clog2(MAX_CARDS + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_VB = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] SCORE   = 3'd3;
    localparam logic [2:0] CLEAR   = 3'd4;

    logic [2:0]               state;
    deal_req_t                req;
    card_t [MAX_CARDS-1:0]    p_tab, d_tab;
    logic [CW-1:0]            p_cnt, d_cnt;
    logic                     vb_q, vb_rise;
    logic                     rescore_pend, hole_hidden;
    logic                     kick, sc_done;
    logic [4:0]               sc_score;
    rank_t [MAX_CARDS-1:0]    sc_ranks;
    logic [MAX_CARDS-1:0]     sc_mask;

    assign vb_rise    = vblnk_in & ~vb_q;
    assign busy       = (state != IDLE);
    assign deal_ready = !rst && (state == IDLE) && !clear_req && !rescore_pend &&
                        ((deal_dealer ? d_cnt : p_cnt) < CW'(MAX_CARDS));

    // Previous vblank level for rise detection.
    always_ff @(posedge clk) begin
        if (rst) vb_q <= 1'b0;
        else     vb_q <= vblnk_in;
    end

`ifdef CARD_SLOT_HOLE_CARD_EN
    logic reveal_lat;
    // Reveal is sticky until the table is cleared; its first sighting
    // requests a dealer rescore so the hole card joins the total.
    always_ff @(posedge clk) begin
        if (rst) begin
            reveal_lat   <= 1'b0;
            rescore_pend <= 1'b0;
        end else if (state == CLEAR && vb_rise) begin
            reveal_lat   <= 1'b0;
            rescore_pend <= 1'b0;
        end else if (reveal && !reveal_lat) begin
            reveal_lat   <= 1'b1;
            rescore_pend <= 1'b1;
        end else if (state == IDLE && !clear_req) begin
            rescore_pend <= 1'b0;
        end
    end
    assign hole_hidden = ~reveal_lat;
`else
    logic unused_reveal;
    assign unused_reveal = reveal;
    assign rescore_pend  = 1'b0;
    assign hole_hidden   = 1'b0;
`endif

    // Select the target hand's ranks and the slots that count toward its score.
    always_comb begin
        for (int i = 0; i < MAX_CARDS; i++) begin
            sc_ranks[i] = req.dealer ? d_tab[i].rank : p_tab[i].rank;
            sc_mask[i]  = (CW'(i) < (req.dealer ? d_cnt : p_cnt)) &&
                          !(req.dealer && hole_hidden && i == 1);
        end
    end

    card_score_unit #(.MAX_CARDS(MAX_CARDS)) u_score (
        .clk      (clk),
        .rst      (rst),
        .start    (kick),
        .ranks    (sc_ranks),
        .use_mask (sc_mask),
        .done     (sc_done),
        .score    (sc_score)
    );

    // Control FSM; tables only change on the WRITE/CLEAR cycles that follow a vblank rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req          <= '0;
            p_tab        <= '0;
            d_tab        <= '0;
            p_cnt        <= '0;
            d_cnt        <= '0;
            player_score <= '0;
            dealer_score <= '0;
            player_bust  <= 1'b0;
            dealer_bust  <= 1'b0;
            kick         <= 1'b0;
        end else begin
            kick <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                    end else if (rescore_pend) begin
                        req   <= {1'b1, 6'd0};
                        kick  <= 1'b1;
                        state <= SCORE;
                    end else if (deal_valid && deal_ready) begin
                        req   <= {deal_dealer, deal_card};
                        state <= WAIT_VB;
                    end
                end
                WAIT_VB: if (vb_rise) state <= WRITE;
                WRITE: begin
                    if (req.dealer) begin
                        d_tab[d_cnt] <= req.card;
                        d_cnt        <= d_cnt + 1'b1;
                    end else begin
                        p_tab[p_cnt] <= req.card;
                        p_cnt        <= p_cnt + 1'b1;
                    end
                    kick  <= 1'b1;
                    state <= SCORE;
                end
                SCORE: begin
                    if (sc_done) begin
                        if (req.dealer) begin
                            dealer_score <= sc_score;
                            dealer_bust  <= (sc_score > 5'd21);
                        end else begin
                            player_score <= sc_score;
                            player_bust  <= (sc_score > 5'd21);
                        end
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (vb_rise) begin
                        p_cnt        <= '0;
                        d_cnt        <= '0;
                        player_score <= '0;
                        dealer_score <= '0;
                        player_bust  <= 1'b0;
                        dealer_bust  <= 1'b0;
                        req          <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-slot horizontal offsets; a pixel left of the slot wraps large and misses.
    logic [MAX_CARDS-1:0][10:0] dx;
    logic [MAX_CARDS-1:0]       in_x;
    logic [10:0]                dy_p, dy_d;
    logic                       in_p, in_d;

    for (genvar g = 0; g < MAX_CARDS; g++) begin : g_slot
        assign dx[g]   = hcount_in - 11'(FIRST_X + g * SLOT_PITCH);
        assign in_x[g] = (dx[g] <= 11'(CARD_W));
    end

    assign dy_p = vcount_in - 11'(PLAYER_Y);
    assign dy_d = vcount_in - 11'(DEALER_Y);
    assign in_p = (dy_p <= 11'(CARD_H));
    assign in_d = (dy_d <= 11'(CARD_H));

    logic        hit_c, fd_c;
    card_t       card_c;
    logic [5:0]  xo_c;
    logic [6:0]  yo_c;

    // Pick the occupied slot under the pixel (slots never overlap).
    always_comb begin
        hit_c  = 1'b0;
        fd_c   = 1'b0;
        card_c = '0;
        xo_c   = '0;
        yo_c   = '0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (in_x[i] && in_p && (CW'(i) < p_cnt)) begin
                hit_c  = 1'b1;
                card_c = p_tab[i];
                xo_c   = dx[i][5:0];
                yo_c   = dy_p[6:0];
                fd_c   = 1'b0;
            end else if (in_x[i] && in_d && (CW'(i) < d_cnt)) begin
                hit_c  = 1'b1;
                card_c = d_tab[i];
                xo_c   = dx[i][5:0];
                yo_c   = dy_d[6:0];
                fd_c   = hole_hidden && (i == 1);
            end
        end
    end

    // One-cycle registered lookup, blanked during vblank.
    always_ff @(posedge clk) begin
        if (rst || vblnk_in || !hit_c) begin
            slot_hit       <= 1'b0;
            slot_card      <= '0;
            slot_face_down <= 1'b0;
            slot_xoff      <= '0;
            slot_yoff      <= '0;
        end else begin
            slot_hit       <= 1'b1;
            slot_card      <= card_c;
            slot_face_down <= fd_c;
            slot_xoff      <= xo_c;
            slot_yoff      <= yo_c;
        end
    end

endmodule

// File: tb/tb_card_slot_ctrl.sv
// Self-checking bench for card_slot_ctrl: directed blackjack scenarios plus
// randomized deals and pixel probes against a hand-level reference model.
// Builds for either setting of CARD_SLOT_HOLE_CARD_EN.
`timescale 1ns/1ps
module tb_card_slot_ctrl;
    localparam int MAXC = 6, PITCH = 60, PY = 400, DY = 30, FX = 20;
`ifdef CARD_SLOT_HOLE_CARD_EN
    localparam bit HOLE = 1'b1;
`else
    localparam bit HOLE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        deal_valid = 1'b0, deal_dealer = 1'b0, clear_req = 1'b0, reveal = 1'b0;
    logic [5:0]  deal_card = '0;
    logic        vblnk_in = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        deal_ready, slot_hit, slot_face_down, player_bust, dealer_bust, busy;
    logic [5:0]  slot_card, slot_xoff;
    logic [6:0]  slot_yoff;
    logic [4:0]  player_score, dealer_score;

    always #5 clk = ~clk;

    card_slot_ctrl dut (
        .clk(clk), .rst(rst), .deal_valid(deal_valid), .deal_ready(deal_ready),
        .deal_dealer(deal_dealer), .deal_card(deal_card), .clear_req(clear_req),
        .reveal(reveal), .vblnk_in(vblnk_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .slot_hit(slot_hit), .slot_card(slot_card), .slot_face_down(slot_face_down),
        .slot_xoff(slot_xoff), .slot_yoff(slot_yoff), .player_score(player_score),
        .dealer_score(dealer_score), .player_bust(player_bust), .dealer_bust(dealer_bust),
        .busy(busy)
    );

    int checks = 0, failures = 0;
    int pq[$], dq[$];
    bit revealed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Best blackjack total of a hand, optionally ignoring slot 1.
    function automatic int best(input int cards[$], input bit hide1);
        int t = 0, a = 0;
        foreach (cards[i]) begin
            int r;
            r = cards[i] >> 2;
            if (!(hide1 && i == 1)) begin
                if (r == 1) begin t += 11; a++; end
                else if (r >= 10) t += 10;
                else t += r;
            end
        end
        while (t > 21 && a > 0) begin t -= 10; a--; end
        return (t > 31) ? 31 : t;
    endfunction

    task automatic chk_scores();
        int ps, ds;
        ps = best(pq, 1'b0);
        ds = best(dq, HOLE && !revealed);
        check("p_score", player_score, ps);
        check("p_bust", player_bust, int'(ps > 21));
        check("d_score", dealer_score, ds);
        check("d_bust", dealer_bust, int'(ds > 21));
    endtask

    task automatic vblank();
        vblnk_in = 1'b0;
        repeat (3) @(negedge clk);
        vblnk_in = 1'b1;
        repeat (4) @(negedge clk);
        vblnk_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check("idle_timeout", busy, 0);
    endtask

    task automatic accept(input bit dlr, input int code);
        int n = 0;
        deal_dealer = dlr;
        deal_card   = 6'(code);
        #1;
        while (!deal_ready && n < 100) begin @(negedge clk); #1; n++; end
        check("deal_ready", deal_ready, 1);
        deal_valid = 1'b1;
        @(negedge clk);
        deal_valid = 1'b0;
    endtask

    task automatic deal(input bit dlr, input int rank, input int suit);
        accept(dlr, rank * 4 + suit);
        vblank();
        wait_idle();
        if (dlr) dq.push_back(rank * 4 + suit);
        else     pq.push_back(rank * 4 + suit);
    endtask

    // Drive one pixel, then compare the registered lookup one cycle later.
    task automatic probe(input int h, input int v, input bit vb);
        int eh = 0, ec = 0, ex = 0, ey = 0, ef = 0;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        vblnk_in  = vb;
        @(negedge clk);
        if (!vb && h >= FX) begin
            int k, rx;
            k  = (h - FX) / PITCH;
            rx = (h - FX) % PITCH;
            if (rx <= 55) begin
                if (v >= PY && v <= PY + 79 && k < pq.size()) begin
                    eh = 1; ec = pq[k]; ex = rx; ey = v - PY;
                end else if (v >= DY && v <= DY + 79 && k < dq.size()) begin
                    eh = 1; ec = dq[k]; ex = rx; ey = v - DY;
                    ef = int'(HOLE && k == 1 && !revealed);
                end
            end
        end
        check("slot_hit", slot_hit, eh);
        check("slot_card", slot_card, ec);
        check("slot_xoff", slot_xoff, ex);
        check("slot_yoff", slot_yoff, ey);
        check("face_down", slot_face_down, ef);
    endtask

    task automatic do_clear();
        deal_dealer = 1'b0;
        deal_card   = 6'h04;
        clear_req   = 1'b1;
        deal_valid  = 1'b1;
        #1;
        check("clr_ready", deal_ready, 0);
        @(negedge clk);
        clear_req  = 1'b0;
        deal_valid = 1'b0;
        check("clr_busy", busy, 1);
        pq.delete();
        dq.delete();
        revealed = 1'b0;
        vblank();
        wait_idle();
        chk_scores();
        probe(FX, PY, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_ready", deal_ready, 0);
        check("rst_hit", slot_hit, 0);
        check("rst_busy", busy, 0);
        chk_scores();
        rst = 1'b0;
        @(negedge clk);

        // A then K across vblanks; nothing visible before the vblank rise
        accept(1'b0, 1 * 4 + 2);
        hcount_in = 11'(FX); vcount_in = 11'(PY); vblnk_in = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_vb_hit", slot_hit, 0);
        check("pre_vb_busy", busy, 1);
        check("pre_vb_score", player_score, 0);
        vblank();
        wait_idle();
        pq.push_back(1 * 4 + 2);
        chk_scores();
        probe(FX, PY, 1'b0);
        probe(FX + 55, PY + 79, 1'b0);
        probe(FX + 56, PY, 1'b0);
        probe(FX, PY, 1'b1);
        deal(1'b0, 13, 0);
        check("ak_21", player_score, 21);
        chk_scores();

        // A, A, 9 -> 21; +5 -> 16; +K -> 26 bust
        do_clear();
        deal(1'b0, 1, 0); deal(1'b0, 1, 1); deal(1'b0, 9, 3);
        check("aa9_21", player_score, 21);
        deal(1'b0, 5, 0);
        check("plus5_16", player_score, 16);
        check("plus5_bust", player_bust, 0);
        deal(1'b0, 13, 1);
        check("plusK_26", player_score, 26);
        check("plusK_bust", player_bust, 1);
        chk_scores();

        // Full player hand blocks player deals only
        do_clear();
        for (int i = 0; i < MAXC; i++) deal(1'b0, $urandom_range(1, 13), $urandom_range(0, 3));
        chk_scores();
        deal_dealer = 1'b0; #1;
        check("full_p_ready", deal_ready, 0);
        deal_dealer = 1'b1; #1;
        check("full_d_ready", deal_ready, 1);
        deal(1'b1, $urandom_range(1, 13), $urandom_range(0, 3));
        chk_scores();
        for (int i = 0; i < MAXC; i++) probe(FX + i * PITCH + $urandom_range(0, 59), PY + $urandom_range(0, 85), 1'b0);

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            int nd;
            do_clear();
            nd = $urandom_range(2, 10);
            for (int j = 0; j < nd; j++) begin
                bit dlr;
                dlr = 1'($urandom_range(0, 1));
                if ((dlr ? dq.size() : pq.size()) < MAXC) begin
                    deal(dlr, $urandom_range(1, 13), $urandom_range(0, 3));
                    chk_scores();
                end
            end
            for (int j = 0; j < 8; j++) begin
                int v;
                v = ($urandom_range(0, 1) != 0) ? PY : DY;
                probe($urandom_range(0, 420), v + $urandom_range(0, 90) - 5, 1'($urandom_range(0, 7) == 0));
            end
        end

`ifdef CARD_SLOT_HOLE_CARD_EN
        // Hole card hidden until reveal
        do_clear();
        deal(1'b1, 10, 0);
        deal(1'b1, 7, 1);
        check("hole_10", dealer_score, 10);
        probe(FX + PITCH, DY, 1'b0);
        check("hole_fd", slot_face_down, 1);
        reveal = 1'b1;
        @(negedge clk);
        reveal = 1'b0;
        revealed = 1'b1;
        @(negedge clk);
        wait_idle();
        check("reveal_17", dealer_score, 17);
        chk_scores();
        probe(FX + PITCH, DY, 1'b0);
`endif

        // Reset while waiting for vblank drops the latched card
        accept(1'b1, 5 * 4 + 1);
        check("wvb_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pq.delete();
        dq.delete();
        revealed = 1'b0;
        check("rst_mid_busy", busy, 0);
        vblank();
        repeat (4) @(negedge clk);
        check("rst_mid_idle", busy, 0);
        chk_scores();
        probe(FX, DY, 1'b0);
        probe(FX, PY, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
